control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Sequencing controller of the mini crypto processor, sitting directly around program_counter. It consumes `pc` and the instruction word fetched at `pc`, and decodes it. It drives the ALU through a start/done handshake. It produces `pc_enable`/`jump`/`jump_addr` back into program_counter: one instruction per pass through a multi-cycle Moore FSM.

Parameters:
ADDR_W, 4, width of `pc`, `jump_addr` and the instruction operand field
INSTR_W, 8, instruction width; opcode = `instr_data[INSTR_W-1 -: 4]`, operand = `instr_data[ADDR_W-1:0]`
ALU_TIMEOUT, 15, max WAIT_ALU cycles before error (used only with CTRL_ALU_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
start  input  1  begin execution from current `pc` (IDLE only)
pc  input  ADDR_W  current program counter from program_counter
instr_data  input  INSTR_W  instruction ROM read data, combinational function of `pc`
zero_flag  input  1  datapath accumulator == 0
alu_done  input  1  ALU result valid, one-cycle pulse
pc_enable  output  1  increment request to program_counter
jump  output  1  load request to program_counter
jump_addr  output  ADDR_W  branch target
alu_start  output  1  one-cycle ALU launch pulse
alu_op  output  3  ALU operation select
operand  output  ADDR_W  immediate to datapath
reg_we  output  1  accumulator write enable
busy  output  1  high in any state except IDLE/HALT
halted  output  1  high in HALT
error  output  1  ALU timeout flag (tied 0 without macro)

Behaviour:
- Opcodes: 0 NOP, 1 LOAD, 2 XOR, 3 ADD, 4 ROTL, 8 JMP, 9 JZ, A JNZ, F HALT. Any other opcode executes as NOP.
- `alu_op` encoding: LOAD=0, XOR=1, ADD=2, ROTL=3.
- Instruction register `ir` captures `instr_data` in FETCH. `operand`, `alu_op` and `jump_addr` come from `ir`.
- All outputs are functions of state and `ir` only; there is no combinational path from any input to any output.
- Reset:
  - state=IDLE, ir=0, timeout counter=0.
  - Every output is 0.
  - Reset in any state, including WAIT_ALU, aborts immediately; a pending `alu_done` is ignored.
- States and transitions:
  - IDLE: `start`=1 -> FETCH, else stay.
  - FETCH: ir<=instr_data -> DECODE.
  - DECODE:
    - ALU op -> EXECUTE.
    - JMP, taken JZ (`zero_flag`=1), taken JNZ (`zero_flag`=0) -> BRANCH.
    - NOP, illegal opcode, untaken branch -> ADVANCE.
    - HALT -> HALT.
  - EXECUTE: `alu_start`=1 for exactly this cycle -> WAIT_ALU.
  - WAIT_ALU: stay until `alu_done`=1, then -> WRITEBACK. `alu_done` is sampled only in this state.
  - WRITEBACK: `reg_we`=1, `pc_enable`=1 -> FETCH.
  - ADVANCE: `pc_enable`=1 -> FETCH.
  - BRANCH: `jump`=1, `jump_addr`=ir operand, `pc_enable`=0 -> FETCH.
  - HALT: absorbing; `halted`=1; only `reset` exits; `start` is ignored.
- `jump` and `pc_enable` are never high in the same cycle.
- Each pulse lasts exactly one cycle, so the PC updates once per instruction. The following FETCH sees the updated `pc` and matching `instr_data`.
- Latency:
  - NOP / untaken branch: 3 cycles.
  - Taken branch: 3 cycles.
  - ALU op: 4 + N cycles, where N ≥ 1 is the number of WAIT_ALU cycles.
- `zero_flag` is sampled in DECODE, which reflects the previous instruction's writeback.
- `start` while `busy` is ignored.
- PC wrap 15->0 is the PC's behaviour; the control unit does not treat it specially.

Optional Feature:
CTRL_ALU_TIMEOUT_EN:
- Defined:
  - A counter clears on entering WAIT_ALU and increments each WAIT_ALU cycle.
  - If it reaches ALU_TIMEOUT without `alu_done`, the FSM goes to HALT with `error`=1 (sticky until reset).
  - `alu_done` in the same cycle as the limit wins, and the FSM goes to WRITEBACK.
- Undefined: no counter; `error` is tied 0; WAIT_ALU waits indefinitely.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - `alu_op` codes;
  - state encoding: IDLE, FETCH, DECODE, EXECUTE, WAIT_ALU, WRITEBACK, ADVANCE, BRANCH, HALT.
- One combinational sub-module, instr_decoder: ir opcode + `zero_flag` -> {is_alu, is_branch_taken, is_halt, alu_op}.

Test Plan:
- Reset then `start`; ROM[0]=NOP, ROM[1]=NOP -> `pc_enable` pulses at cycles 3 and 6 after `start`; `jump` stays 0; `busy`=1.
- ROM[0]=XOR 0x5; ALU returns `alu_done` 2 cycles after `alu_start` -> `alu_start` one cycle, `alu_op`=1, `operand`=5, then `reg_we` and `pc_enable` together for one cycle.
- ROM[2]=JMP 0xA -> `jump`=1, `jump_addr`=10 for one cycle, `pc_enable`=0; next FETCH latches ROM[10].
- JZ 0x3 with `zero_flag`=0 -> ADVANCE, `pc_enable` pulse, no `jump`; repeat with `zero_flag`=1 -> `jump`, `jump_addr`=3.
- HALT opcode F -> `halted`=1, `busy`=0; `start` pulses ignored; `reset` -> IDLE, all outputs 0.
- Reset asserted in WAIT_ALU, then a late `alu_done` -> no `reg_we`/`pc_enable`. With CTRL_ALU_TIMEOUT_EN and ALU_TIMEOUT=4 and no `alu_done` -> `error`=1 and HALT after 4 WAIT_ALU cycles.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the mini crypto processor control unit: opcodes, ALU
// operation codes and FSM states.
package ctrl_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LOAD = 4'h1;
   localparam logic [3:0] OP_XOR  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_ROTL = 4'h4;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_JNZ  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_LOAD = 3'd0;
   localparam logic [2:0] ALU_XOR  = 3'd1;
   localparam logic [2:0] ALU_ADD  = 3'd2;
   localparam logic [2:0] ALU_ROTL = 3'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_WAIT_ALU,
      ST_WRITEBACK,
      ST_ADVANCE,
      ST_BRANCH,
      ST_HALT
   } state_t;

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Combinational opcode classifier: splits an opcode into ALU / branch / halt
// classes and resolves conditional branches against zero_flag.
module instr_decoder
   import ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       zero_flag,
   output logic       is_alu,
   output logic       is_branch_taken,
   output logic       is_halt,
   output logic [2:0] alu_op
);

   always_comb begin
      is_alu          = 1'b0;
      is_branch_taken = 1'b0;
      is_halt         = 1'b0;
      alu_op          = ALU_LOAD;
      case (opcode)
         OP_LOAD: begin is_alu = 1'b1; alu_op = ALU_LOAD; end
         OP_XOR:  begin is_alu = 1'b1; alu_op = ALU_XOR;  end
         OP_ADD:  begin is_alu = 1'b1; alu_op = ALU_ADD;  end
         OP_ROTL: begin is_alu = 1'b1; alu_op = ALU_ROTL; end
         OP_JMP:  is_branch_taken = 1'b1;
         OP_JZ:   is_branch_taken = zero_flag;
         OP_JNZ:  is_branch_taken = ~zero_flag;
         OP_HALT: is_halt = 1'b1;
         // NOP and unassigned opcodes fall through as NOP
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer around program_counter, one instruction per pass.
// Optional ALU watchdog enabled by defining CTRL_ALU_TIMEOUT_EN.
module control_unit
   import ctrl_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int INSTR_W     = 8,
   parameter int ALU_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  pc,
   input  logic [INSTR_W-1:0] instr_data,
   input  logic               zero_flag,
   input  logic               alu_done,
   output logic               pc_enable,
   output logic               jump,
   output logic [ADDR_W-1:0]  jump_addr,
   output logic               alu_start,
   output logic [2:0]         alu_op,
   output logic [ADDR_W-1:0]  operand,
   output logic               reg_we,
   output logic               busy,
   output logic               halted,
   output logic               error
);

   if (ALU_TIMEOUT < 1 || INSTR_W < 4 || ADDR_W > INSTR_W) begin : g_bad_cfg
      $error("control_unit: invalid parameter combination");
   end

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               pc_enable_q, pc_enable_d;
   logic               jump_q, jump_d;
   logic               alu_start_q, alu_start_d;
   logic               reg_we_q, reg_we_d;
   logic               busy_q, busy_d;
   logic               halted_q, halted_d;

   logic               dec_is_alu, dec_is_branch, dec_is_halt;
   logic [2:0]         dec_alu_op;

`ifdef CTRL_ALU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               error_q, error_d;
`endif

   // pc is consumed by program_counter and the ROM; the controller only needs the fetched word
   logic unused_pc;
   assign unused_pc = ^pc;

   instr_decoder u_decoder (
      .opcode          (ir_q[INSTR_W-1 -: 4]),
      .zero_flag       (zero_flag),
      .is_alu          (dec_is_alu),
      .is_branch_taken (dec_is_branch),
      .is_halt         (dec_is_halt),
      .alu_op          (dec_alu_op)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
`ifdef CTRL_ALU_TIMEOUT_EN
      cnt_d   = cnt_q;
      error_d = error_q;
`endif
      case (state_q)
         ST_IDLE:      if (start) state_d = ST_FETCH;
         ST_FETCH: begin
            ir_d    = instr_data;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (dec_is_halt)        state_d = ST_HALT;
            else if (dec_is_alu)    state_d = ST_EXECUTE;
            else if (dec_is_branch) state_d = ST_BRANCH;
            else                    state_d = ST_ADVANCE;
         end
         ST_EXECUTE: begin
            state_d = ST_WAIT_ALU;
`ifdef CTRL_ALU_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT_ALU: begin
            // alu_done takes priority over a watchdog expiry in the same cycle
            if (alu_done) begin
               state_d = ST_WRITEBACK;
            end
`ifdef CTRL_ALU_TIMEOUT_EN
            else if (cnt_q == CNT_W'(ALU_TIMEOUT - 1)) begin
               state_d = ST_HALT;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_WRITEBACK, ST_ADVANCE, ST_BRANCH: state_d = ST_FETCH;
         ST_HALT:      state_d = ST_HALT;
         default:      state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered with it
      pc_enable_d = (state_d == ST_WRITEBACK) || (state_d == ST_ADVANCE);
      jump_d      = (state_d == ST_BRANCH);
      alu_start_d = (state_d == ST_EXECUTE);
      reg_we_d    = (state_d == ST_WRITEBACK);
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
      halted_d    = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ir_q        <= '0;
         pc_enable_q <= 1'b0;
         jump_q      <= 1'b0;
         alu_start_q <= 1'b0;
         reg_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
`ifdef CTRL_ALU_TIMEOUT_EN
         cnt_q       <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         pc_enable_q <= pc_enable_d;
         jump_q      <= jump_d;
         alu_start_q <= alu_start_d;
         reg_we_q    <= reg_we_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
`ifdef CTRL_ALU_TIMEOUT_EN
         cnt_q       <= cnt_d;
         error_q     <= error_d;
`endif
      end
   end

   assign pc_enable = pc_enable_q;
   assign jump      = jump_q;
   assign alu_start = alu_start_q;
   assign reg_we    = reg_we_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign operand   = ir_q[ADDR_W-1:0];
   assign jump_addr = ir_q[ADDR_W-1:0];
   assign alu_op    = dec_alu_op;
`ifdef CTRL_ALU_TIMEOUT_EN
   assign error     = error_q;
`else
   assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Cycle-stepped bench for control_unit with a program_counter/ROM model and an
// expected-output queue; timeout path exercised when CTRL_ALU_TIMEOUT_EN is set.
module tb_control_unit;

`ifdef CTRL_ALU_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 15;
`endif

   logic       clk = 1'b0;
   logic       reset, start, zero_flag, alu_done;
   logic [3:0] pc;
   logic [7:0] instr_data;
   logic       pc_enable, jump, alu_start, reg_we, busy, halted, error;
   logic [3:0] jump_addr, operand;
   logic [2:0] alu_op;
   logic [7:0] rom [16];

   // packed layout: pe jp ja[4] as op[3] opd[4] we busy halt err
   typedef struct {
      logic        rst;
      logic        st;
      logic        zf;
      logic        dn;
      logic [17:0] exp;
   } vec_t;

   logic [17:0] exp_q[$];
   int          total  = 0;
   int          passed = 0;
   vec_t        tbl [38];

   always #5 clk = ~clk;

   control_unit #(.ADDR_W(4), .INSTR_W(8), .ALU_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .pc(pc), .instr_data(instr_data),
      .zero_flag(zero_flag), .alu_done(alu_done), .pc_enable(pc_enable),
      .jump(jump), .jump_addr(jump_addr), .alu_start(alu_start), .alu_op(alu_op),
      .operand(operand), .reg_we(reg_we), .busy(busy), .halted(halted), .error(error)
   );

   // program_counter model and combinational ROM
   always @(posedge clk) begin
      if (reset)          pc <= 4'd0;
      else if (jump)      pc <= jump_addr;
      else if (pc_enable) pc <= pc + 4'd1;
   end
   assign instr_data = rom[pc];

   function automatic vec_t mk(input logic rst, st, zf, dn,
                               input logic pe, jp, as_, we, bsy, hlt, err,
                               input logic [2:0] op, input logic [3:0] opd);
      vec_t v;
      v.rst = rst; v.st = st; v.zf = zf; v.dn = dn;
      v.exp = {pe, jp, opd, as_, op, opd, we, bsy, hlt, err};
      return v;
   endfunction

   task automatic step(input string name, input vec_t v);
      logic [17:0] got, want;
      reset = v.rst; start = v.st; zero_flag = v.zf; alu_done = v.dn;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      got  = {pc_enable, jump, jump_addr, alu_start, alu_op, operand, reg_we, busy, halted, error};
      want = exp_q.pop_front();
      total++;
      if (got !== want)
         $display("FAIL %s: got pe,jp,ja,as,op,opd,we,busy,halt,err=%b want %b", name, got, want);
      else
         passed++;
   endtask

   initial begin
      pc = 4'd0;
      reset = 1'b1; start = 1'b0; zero_flag = 1'b0; alu_done = 1'b0;
      foreach (rom[i]) rom[i] = 8'h00;
      rom[2]  = 8'h25;  // XOR 5
      rom[3]  = 8'h8A;  // JMP A
      rom[4]  = 8'hF0;  // HALT
      rom[10] = 8'h93;  // JZ 3, untaken
      rom[11] = 8'h17;  // LOAD 7
      rom[12] = 8'h56;  // illegal -> NOP
      rom[13] = 8'h94;  // JZ 4, taken

      //            rst st zf dn  pe jp as we by ht er  op    opd
      tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0);
      tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0);
      tbl[2]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0);
      tbl[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0);
      tbl[4]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0);
      tbl[5]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0);
      tbl[6]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0);
      tbl[7]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0);
      tbl[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0);
      tbl[9]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd1, 4'h5);
      tbl[10] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 3'd1, 4'h5);
      tbl[11] = mk(0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 3'd1, 4'h5);
      tbl[12] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd1, 4'h5);
      tbl[13] = mk(0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 0, 3'd1, 4'h5);
      tbl[14] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd1, 4'h5);
      tbl[15] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'hA);
      tbl[16] = mk(0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0, 3'd0, 4'hA);
      tbl[17] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'hA);
      tbl[18] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h3);
      tbl[19] = mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 3'd0, 4'h3);
      tbl[20] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h3);
      tbl[21] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h7);
      tbl[22] = mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 3'd0, 4'h7);
      tbl[23] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h7);
      tbl[24] = mk(0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 0, 3'd0, 4'h7);
      tbl[25] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h7);
      tbl[26] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h6);
      tbl[27] = mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 3'd0, 4'h6);
      tbl[28] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h6);
      tbl[29] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h4);
      tbl[30] = mk(0, 0, 1, 0,  0, 1, 0, 0, 1, 0, 0, 3'd0, 4'h4);
      tbl[31] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h4);
      tbl[32] = mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0);
      tbl[33] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 3'd0, 4'h0);
      tbl[34] = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 3'd0, 4'h0);
      tbl[35] = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 3'd0, 4'h0);
      tbl[36] = mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0);
      tbl[37] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0);

      @(posedge clk); #1;
      for (int i = 0; i < 38; i++) step($sformatf("vec%0d", i), tbl[i]);

      // reset while waiting on the ALU; the late alu_done must not write back
      rom[0] = 8'h4C;  // ROTL C
      step("abort_fetch",  mk(0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0));
      step("abort_decode", mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd3, 4'hC));
      step("abort_exec",   mk(0, 1, 0, 0,  0, 0, 1, 0, 1, 0, 0, 3'd3, 4'hC));
      step("abort_wait",   mk(0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd3, 4'hC));
      step("abort_reset",  mk(1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0));
      step("abort_late1",  mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0));
      step("abort_late2",  mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0));

      step("wd_fetch",     mk(0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd0, 4'h0));
      step("wd_decode",    mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd3, 4'hC));
      step("wd_exec",      mk(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 3'd3, 4'hC));
      for (int i = 0; i < 4; i++)
         step($sformatf("wd_wait%0d", i), mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd3, 4'hC));
`ifdef CTRL_ALU_TIMEOUT_EN
      step("wd_expire",    mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 3'd3, 4'hC));
      step("wd_sticky",    mk(0, 1, 0, 1,  0, 0, 0, 0, 0, 1, 1, 3'd3, 4'hC));
`else
      step("wd_wait4",     mk(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 3'd3, 4'hC));
      step("wd_done",      mk(0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 0, 3'd3, 4'hC));
`endif
      step("wd_reset",     mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3'd0, 4'h0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
